// File: rtl/pkg_boot_loader.sv
// Shared types and constants for the boot loader: FSM states, error codes and
// the default packet start marker.
package pkg_boot_loader;

  typedef enum logic [2:0] {
    S_SYNC   = 3'd0,
    S_LEN_LO = 3'd1,
    S_LEN_HI = 3'd2,
    S_DATA   = 3'd3,
    S_CSUM   = 3'd4,
    S_RUN    = 3'd5,
    S_ERR    = 3'd6
  } state_e;

  typedef enum logic [1:0] {
    ERR_NONE    = 2'd0,
    ERR_CSUM    = 2'd1,
    ERR_TIMEOUT = 2'd2,
    ERR_LEN     = 2'd3
  } err_code_e;

  localparam logic [7:0] SYNC_BYTE_DEFAULT = 8'hA5;

  // States in which a packet is being received and the timeout is armed.
  function automatic logic is_busy(input state_e s);
    return (s == S_LEN_LO) || (s == S_LEN_HI) || (s == S_DATA) || (s == S_CSUM);
  endfunction

endpackage

// File: rtl/module_timeout_counter.sv
// Inter-byte idle counter; expired_o pulses for one cycle so that the owner
// acts on it exactly TIMEOUT_CYCLES cycles after the last clear.
module module_timeout_counter #(
  parameter int TIMEOUT_CYCLES = 10_000_000
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clear_i,
  input  logic enable_i,
  output logic expired_o
);

  localparam int CW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 2;
  // The pulse is registered, so it is raised one count early.
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYCLES - 2);

  logic [CW-1:0] cnt_q, cnt_d;
  logic          expired_q, expired_d;

  // Next count and expiry pulse.
  always_comb begin
    cnt_d     = cnt_q;
    expired_d = 1'b0;
    if (clear_i) begin
      cnt_d     = '0;
      expired_d = 1'b0;
    end else if (enable_i) begin
      cnt_d     = cnt_q + CW'(1);
      expired_d = (cnt_q == LAST);
    end else begin
      cnt_d     = cnt_q;
      expired_d = 1'b0;
    end
  end

  // Counter and pulse registers.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q     <= '0;
      expired_q <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      expired_q <= expired_d;
    end
  end

  assign expired_o = expired_q;

endmodule

// File: rtl/module_boot_loader.sv
// Boot sequencer: holds the core in reset, loads a framed byte stream into
// instruction memory, verifies length and XOR checksum, then releases the core.
module module_boot_loader
  import pkg_boot_loader::*;
#(
  parameter int         IMEM_DEPTH     = 1024,
  parameter int         TIMEOUT_CYCLES = 10_000_000,
  parameter logic [7:0] SYNC_BYTE      = SYNC_BYTE_DEFAULT
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        rx_valid_i,
  input  logic [7:0]  rx_data_i,
  output logic        rx_ready_o,
  input  logic        reload_i,
  output logic        imem_we_o,
  output logic [31:0] imem_addr_o,
  output logic [31:0] imem_wdata_o,
  output logic        cpu_rst_o,
  output logic        busy_o,
  output logic        done_o,
  output logic        error_o,
  output logic [1:0]  err_code_o
);

  localparam int         IDXW    = $clog2(IMEM_DEPTH) + 1;
  localparam logic [16:0] DEPTH17 = 17'(IMEM_DEPTH);

  state_e            state_q, state_d;
  err_code_e         err_code_q, err_code_d;
  logic [15:0]       len_q, len_d;
  logic [IDXW-1:0]   word_idx_q, word_idx_d;
  logic [1:0]        byte_cnt_q, byte_cnt_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [7:0]        csum_q, csum_d;
  logic              imem_we_q, imem_we_d;
  logic [31:0]       imem_addr_q, imem_addr_d;
  logic [31:0]       imem_wdata_q, imem_wdata_d;
  logic              rx_ready_q, rx_ready_d;
  logic              cpu_rst_q, cpu_rst_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              error_q, error_d;

  logic              accept_s;
  logic              loading_s;
  logic              expired_s;

  assign accept_s  = rx_valid_i && rx_ready_q;
  assign loading_s = is_busy(state_q);

  module_timeout_counter #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timeout (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .clear_i  (accept_s || !loading_s),
    .enable_i (loading_s),
    .expired_o(expired_s)
  );

  // Next-state, packet assembly and registered output values.
  always_comb begin
    state_d      = state_q;
    err_code_d   = err_code_q;
    len_d        = len_q;
    word_idx_d   = word_idx_q;
    byte_cnt_d   = byte_cnt_q;
    wdata_d      = wdata_q;
    csum_d       = csum_q;
    imem_we_d    = 1'b0;
    imem_addr_d  = imem_addr_q;
    imem_wdata_d = imem_wdata_q;

    // A timeout wins over a byte arriving in the same cycle.
    if (loading_s && expired_s) begin
      state_d    = S_ERR;
      err_code_d = ERR_TIMEOUT;
    end else begin
      case (state_q)
        S_SYNC: begin
          word_idx_d = '0;
          byte_cnt_d = 2'd0;
          csum_d     = 8'd0;
          wdata_d    = 32'd0;
          if (accept_s && (rx_data_i == SYNC_BYTE)) begin
            state_d = S_LEN_LO;
          end else begin
            state_d = S_SYNC;
          end
        end
        S_LEN_LO: begin
          if (accept_s) begin
            len_d   = {len_q[15:8], rx_data_i};
            state_d = S_LEN_HI;
          end else begin
            state_d = S_LEN_LO;
          end
        end
        S_LEN_HI: begin
          if (accept_s) begin
            len_d = {rx_data_i, len_q[7:0]};
            if ({1'b0, len_d} > DEPTH17) begin
              state_d    = S_ERR;
              err_code_d = ERR_LEN;
            end else if (len_d == 16'd0) begin
              state_d = S_CSUM;
            end else begin
              state_d = S_DATA;
            end
          end else begin
            state_d = S_LEN_HI;
          end
        end
        S_DATA: begin
          if (accept_s) begin
            csum_d     = csum_q ^ rx_data_i;
            byte_cnt_d = byte_cnt_q + 2'd1;
            wdata_d[{byte_cnt_q, 3'b000} +: 8] = rx_data_i;
            if (byte_cnt_q == 2'd3) begin
              imem_we_d    = 1'b1;
              imem_addr_d  = 32'(word_idx_q) << 2;
              imem_wdata_d = {rx_data_i, wdata_q[23:0]};
              word_idx_d   = word_idx_q + IDXW'(1);
              if (16'(word_idx_q) == (len_q - 16'd1)) begin
                state_d = S_CSUM;
              end else begin
                state_d = S_DATA;
              end
            end else begin
              state_d = S_DATA;
            end
          end else begin
            state_d = S_DATA;
          end
        end
        S_CSUM: begin
          if (accept_s) begin
            if (rx_data_i == csum_q) begin
              state_d = S_RUN;
            end else begin
              state_d    = S_ERR;
              err_code_d = ERR_CSUM;
            end
          end else begin
            state_d = S_CSUM;
          end
        end
        S_RUN: begin
          if (reload_i) begin
            state_d = S_SYNC;
          end else begin
            state_d = S_RUN;
          end
        end
        S_ERR: begin
          word_idx_d = '0;
          byte_cnt_d = 2'd0;
          csum_d     = 8'd0;
          wdata_d    = 32'd0;
          if (accept_s && (rx_data_i == SYNC_BYTE)) begin
            state_d    = S_LEN_LO;
            err_code_d = ERR_NONE;
          end else begin
            state_d = S_ERR;
          end
        end
        default: begin
          state_d = S_SYNC;
        end
      endcase
    end

    rx_ready_d = (state_d != S_RUN);
    cpu_rst_d  = (state_d != S_RUN);
    done_d     = (state_d == S_RUN);
    busy_d     = is_busy(state_d);
    error_d    = (state_d == S_ERR);
  end

  // State and output registers.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q      <= S_SYNC;
      err_code_q   <= ERR_NONE;
      len_q        <= 16'd0;
      word_idx_q   <= '0;
      byte_cnt_q   <= 2'd0;
      wdata_q      <= 32'd0;
      csum_q       <= 8'd0;
      imem_we_q    <= 1'b0;
      imem_addr_q  <= 32'd0;
      imem_wdata_q <= 32'd0;
      rx_ready_q   <= 1'b1;
      cpu_rst_q    <= 1'b1;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      error_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      err_code_q   <= err_code_d;
      len_q        <= len_d;
      word_idx_q   <= word_idx_d;
      byte_cnt_q   <= byte_cnt_d;
      wdata_q      <= wdata_d;
      csum_q       <= csum_d;
      imem_we_q    <= imem_we_d;
      imem_addr_q  <= imem_addr_d;
      imem_wdata_q <= imem_wdata_d;
      rx_ready_q   <= rx_ready_d;
      cpu_rst_q    <= cpu_rst_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      error_q      <= error_d;
    end
  end

  assign rx_ready_o   = rx_ready_q;
  assign imem_we_o    = imem_we_q;
  assign imem_addr_o  = imem_addr_q;
  assign imem_wdata_o = imem_wdata_q;
  assign cpu_rst_o    = cpu_rst_q;
  assign busy_o       = busy_q;
  assign done_o       = done_q;
  assign error_o      = error_q;
  assign err_code_o   = err_code_q;

endmodule

// File: tb/tb_module_boot_loader.sv
// Bench for module_boot_loader: directed packets, expected imem writes queued
// into a scoreboard and checked by an independent monitor.
module tb_module_boot_loader;

  logic        clk = 1'b0;
  logic        rst;
  logic        rx_valid;
  logic [7:0]  rx_data;
  logic        rx_ready;
  logic        reload;
  logic        imem_we;
  logic [31:0] imem_addr;
  logic [31:0] imem_wdata;
  logic        cpu_rst;
  logic        busy;
  logic        done;
  logic        error;
  logic [1:0]  err_code;

  int checks = 0;
  int failures = 0;
  int writes_seen = 0;
  logic [63:0] exp_q[$];

  always #5 clk = ~clk;

  module_boot_loader #(
    .IMEM_DEPTH    (16),
    .TIMEOUT_CYCLES(100),
    .SYNC_BYTE     (8'hA5)
  ) dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .rx_valid_i  (rx_valid),
    .rx_data_i   (rx_data),
    .rx_ready_o  (rx_ready),
    .reload_i    (reload),
    .imem_we_o   (imem_we),
    .imem_addr_o (imem_addr),
    .imem_wdata_o(imem_wdata),
    .cpu_rst_o   (cpu_rst),
    .busy_o      (busy),
    .done_o      (done),
    .error_o     (error),
    .err_code_o  (err_code)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Monitor: every write strobe must match the oldest queued expectation.
  always @(negedge clk) begin
    if (imem_we === 1'b1) begin
      writes_seen++;
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_write actual=%h:%h required=none", imem_addr, imem_wdata);
      end else begin
        logic [63:0] e;
        e = exp_q.pop_front();
        chk("wr_addr", imem_addr, e[63:32]);
        chk("wr_data", imem_wdata, e[31:0]);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1);
  end

  task automatic send(input logic [7:0] b);
    chk("rx_ready", rx_ready, 1);
    rx_valid = 1'b1;
    rx_data  = b;
    @(negedge clk);
    rx_valid = 1'b0;
    rx_data  = 8'h00;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic status(input string tag, input logic c_rst, input logic c_done,
                        input logic c_err, input logic [1:0] c_code, input logic c_busy);
    chk({tag, ".cpu_rst"}, cpu_rst, c_rst);
    chk({tag, ".done"}, done, c_done);
    chk({tag, ".error"}, error, c_err);
    chk({tag, ".err_code"}, err_code, c_code);
    chk({tag, ".busy"}, busy, c_busy);
    chk({tag, ".rx_ready"}, rx_ready, !c_done);
  endtask

  task automatic chk_reset(input string tag);
    status(tag, 1'b1, 1'b0, 1'b0, 2'd0, 1'b0);
    chk({tag, ".we"}, imem_we, 0);
    chk({tag, ".addr"}, imem_addr, 0);
    chk({tag, ".wdata"}, imem_wdata, 0);
  endtask

  task automatic do_reload();
    reload = 1'b1;
    @(negedge clk);
    reload = 1'b0;
    chk("reload.cpu_rst", cpu_rst, 1);
    chk("reload.done", done, 0);
    chk("reload.rx_ready", rx_ready, 1);
  endtask

  // The two-word reference packet, with a caller-chosen checksum byte.
  task automatic pkt1(input logic [7:0] csum);
    logic [7:0] body[11];
    body = '{8'hA5, 8'h02, 8'h00, 8'h13, 8'h05, 8'h10, 8'h00, 8'h93, 8'h05, 8'h20, 8'h00};
    exp_q.push_back({32'h0000_0000, 32'h0010_0513});
    exp_q.push_back({32'h0000_0004, 32'h0020_0593});
    foreach (body[i]) send(body[i]);
    chk("pkt1.pre_csum_cpu_rst", cpu_rst, 1);
    chk("pkt1.pre_csum_busy", busy, 1);
    send(csum);
  endtask

  initial begin
    logic [7:0] p5[10];
    rst = 1'b1; rx_valid = 1'b0; rx_data = 8'h00; reload = 1'b0;
    idle(3);
    chk_reset("reset");
    rst = 1'b0;

    // Valid load, core released one cycle after the checksum byte.
    pkt1(8'hB0);
    status("t1", 1'b0, 1'b1, 1'b0, 2'd0, 1'b0);
    chk("t1.writes", writes_seen, 2);
    chk("t1.sb_empty", exp_q.size(), 0);
    do_reload();

    // Bad checksum, reload ignored in ERR, then recovery.
    pkt1(8'hB1);
    status("t2.bad", 1'b1, 1'b0, 1'b1, 2'd1, 1'b0);
    do_reload();
    chk("t2.ignored_reload.error", error, 1);
    chk("t2.ignored_reload.code", err_code, 1);
    pkt1(8'hB0);
    status("t2.good", 1'b0, 1'b1, 1'b0, 2'd0, 1'b0);
    chk("t2.writes", writes_seen, 6);
    do_reload();

    // Timeout: error appears exactly 100 cycles after the last byte.
    send(8'hA5); send(8'h02); send(8'h00); send(8'h13);
    idle(99);
    status("t3.before", 1'b1, 1'b0, 1'b0, 2'd0, 1'b1);
    idle(1);
    status("t3.after", 1'b1, 1'b0, 1'b1, 2'd2, 1'b0);
    chk("t3.writes", writes_seen, 6);

    // Length above IMEM_DEPTH, then an empty image.
    send(8'hA5); send(8'h11); send(8'h00);
    status("t4.len", 1'b1, 1'b0, 1'b1, 2'd3, 1'b0);
    send(8'hA5); send(8'h00); send(8'h00); send(8'h00);
    status("t4.empty", 1'b0, 1'b1, 1'b0, 2'd0, 1'b0);
    chk("t4.writes", writes_seen, 6);
    do_reload();

    // Junk before the marker and random gaps inside words.
    send(8'h00); send(8'hFF);
    status("t5.junk", 1'b1, 1'b0, 1'b0, 2'd0, 1'b0);
    exp_q.push_back({32'h0000_0000, 32'h1234_5678});
    exp_q.push_back({32'h0000_0004, 32'hDEAD_BEEF});
    p5 = '{8'hA5, 8'h02, 8'h00, 8'h78, 8'h56, 8'h34, 8'h12, 8'hEF, 8'hBE, 8'hAD};
    foreach (p5[i]) begin
      send(p5[i]);
      idle($urandom_range(0, 6));
    end
    send(8'hDE);
    idle($urandom_range(0, 6));
    send(8'h2A);
    status("t5.run", 1'b0, 1'b1, 1'b0, 2'd0, 1'b0);
    chk("t5.writes", writes_seen, 8);
    do_reload();

    // Reset in the middle of DATA, then a fresh load from address 0.
    send(8'hA5); send(8'h02); send(8'h00); send(8'h13); send(8'h05);
    rst = 1'b1;
    idle(1);
    chk_reset("t6.rst");
    rst = 1'b0;
    pkt1(8'hB0);
    status("t6.run", 1'b0, 1'b1, 1'b0, 2'd0, 1'b0);
    chk("t6.writes", writes_seen, 10);
    chk("t6.sb_empty", exp_q.size(), 0);

    idle(2);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/module_boot_loader.md
Name: module_boot_loader

Overview:
- Boot sequencer for the single-cycle RISC-V core.
- Holds the core in reset and receives a program image as a byte stream (UART RX side) over a valid/ready handshake.
- Assembles 32-bit little-endian words, writes them into instruction memory, checks a length and an XOR checksum, then releases the core.
- On a reload request it puts the core back into reset and waits for a new image.

Parameters:
- IMEM_DEPTH, 1024, instruction memory size in 32-bit words; maximum accepted word count.
- TIMEOUT_CYCLES, 10_000_000, idle clock cycles allowed between bytes during a load.
- SYNC_BYTE, 8'hA5, packet start marker.

Ports:
- clk_i  in  1  system clock.
- rst_i  in  1  synchronous, active-high reset.
- rx_valid_i  in  1  byte available on rx_data_i.
- rx_data_i  in  8  received byte.
- rx_ready_o  out  1  loader accepts a byte; transfer occurs when rx_valid_i && rx_ready_o.
- reload_i  in  1  single-cycle request to reload the program.
- imem_we_o  out  1  instruction memory write strobe, one cycle per word.
- imem_addr_o  out  32  byte address of the write (word index × 4).
- imem_wdata_o  out  32  assembled instruction word.
- cpu_rst_o  out  1  reset to the core; 1 = core held in reset.
- busy_o  out  1  load in progress (states LEN_LO..CSUM).
- done_o  out  1  image loaded, core running.
- error_o  out  1  last load failed.
- err_code_o  out  2  0 none, 1 checksum, 2 timeout, 3 length.

Behaviour:
- Reset values:
  - state = SYNC, cpu_rst_o = 1, rx_ready_o = 1.
  - imem_we_o = 0, imem_addr_o = 0, imem_wdata_o = 0.
  - busy_o = 0, done_o = 0, error_o = 0, err_code_o = 0.
- rx_ready_o is 1 in SYNC, LEN_LO, LEN_HI, DATA, CSUM and ERR; it is 0 in RUN. At most one byte is accepted per cycle.
- States and transitions (each transition on an accepted byte unless noted):
  - SYNC: byte == SYNC_BYTE → LEN_LO; any other byte is discarded. Clear word index, byte counter and checksum.
  - LEN_LO: byte → len[7:0].
  - LEN_HI: byte → len[15:8].
    - len > IMEM_DEPTH → ERR, code 3.
    - len == 0 → CSUM.
    - otherwise → DATA.
  - DATA: byte k of the current word goes to wdata[8k+7:8k]. checksum ^= byte.
    - After the 4th byte (accepted in cycle N), in cycle N+1: imem_we_o = 1 for exactly one cycle, imem_addr_o = word_idx×4, imem_wdata_o = the assembled word.
    - word_idx then increments. After word len−1 → CSUM.
  - CSUM: byte == checksum → RUN; otherwise → ERR, code 1.
  - RUN: cpu_rst_o = 0, done_o = 1, from the cycle after the checksum byte is accepted. reload_i → SYNC with cpu_rst_o = 1 and done_o = 0 the next cycle.
  - ERR: cpu_rst_o = 1, error_o = 1, err_code_o held. A SYNC_BYTE → LEN_LO and clears error_o/err_code_o; other bytes are discarded.
- Timeout:
  - Counter runs in LEN_LO..CSUM and is cleared on every accepted byte and on state entry.
  - Reaching TIMEOUT_CYCLES → ERR, code 2. A byte accepted in the same cycle is discarded.
- cpu_rst_o stays 1 in every state except RUN. The final imem write always precedes the core's release by at least one cycle.
- reload_i is ignored outside RUN.
- rst_i mid-load: everything returns to reset values. Already written memory words are left as is; the core stays in reset.
- Length is 16-bit unsigned. word_idx width is clog2(IMEM_DEPTH)+1.

Decomposition:
- Package pkg_boot_loader:
  - state enum (S_SYNC, S_LEN_LO, S_LEN_HI, S_DATA, S_CSUM, S_RUN, S_ERR).
  - err_code enum (ERR_NONE, ERR_CSUM, ERR_TIMEOUT, ERR_LEN).
  - default SYNC_BYTE constant.
- Sub-module module_timeout_counter: clear/enable inputs, TIMEOUT_CYCLES parameter, single-cycle expired output.
- Byte-to-word assembly stays in the top FSM.

Test Plan:
1. Valid load: bytes A5, 02 00, 13 05 10 00, 93 05 20 00, checksum B0 → two writes:
   - addr 0x0 data 0x00100513;
   - addr 0x4 data 0x00200593.
   Then cpu_rst_o falls, done_o = 1 and rx_ready_o = 0 one cycle after B0 is accepted.
2. Same packet with checksum B1 → error_o = 1, err_code_o = 1, cpu_rst_o stays 1. Resending the valid packet → done_o = 1, err_code_o = 0.
3. With TIMEOUT_CYCLES = 100: send A5 02 00 13, then no byte for 100 cycles → err_code_o = 2 exactly 100 cycles after the last accepted byte; no imem write.
4. With IMEM_DEPTH = 16: send A5 11 00 → err_code_o = 3 and zero imem writes. Send A5 00 00 00 → RUN with no writes.
5. Junk and gaps: 00 FF before A5 are ignored. rx_valid_i is deasserted for random gaps inside words, with correct assembly and little-endian order.
6. reload_i in RUN → cpu_rst_o = 1 next cycle, state SYNC. rst_i asserted during DATA → all outputs return to reset values and the next valid packet loads from address 0.
